// File: rtl/cmp_share_arbiter.sv
// Round-robin share of one magnitude comparator among NREQ requesters.
// Define CMP_SIGNED_EN for two's-complement compare; default is unsigned.
module cmp_share_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_grt,
  output logic                  rsp_less,
  output logic                  rsp_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             grt_q;
  logic             less_q;
  logic             eq_q;

  logic [IDW-1:0]   grant;
  logic             found;
  int               idx;
  logic             gt;
  logic             lt;
  logic             eq;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready = NREQ'(1) << grant;
  end

`ifdef CMP_SIGNED_EN
  assign gt = $signed(a_q) > $signed(b_q);
  assign lt = $signed(a_q) < $signed(b_q);
`else
  assign gt = a_q > b_q;
  assign lt = a_q < b_q;
`endif
  assign eq = a_q == b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      grt_q  <= 1'b0;
      less_q <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            a_q   <= req_a[grant*WIDTH +: WIDTH];
            b_q   <= req_b[grant*WIDTH +: WIDTH];
            id_q  <= grant;
            state <= CMP;
          end
        end
        CMP: begin
          grt_q  <= gt;
          less_q <= lt;
          eq_q   <= eq;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state  <= IDLE;
            rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flags are only visible while the response is being offered.
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_grt   = rsp_valid & grt_q;
  assign rsp_less  = rsp_valid & less_q;
  assign rsp_eq    = rsp_valid & eq_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed testbench for cmp_share_arbiter (NREQ=4, WIDTH=4).
module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_grt;
  logic        rsp_less;
  logic        rsp_eq;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] F_GRT  = 3'b100;
  localparam logic [2:0] F_LESS = 3'b010;
  localparam logic [2:0] F_EQ   = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  cmp_share_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_grt   (rsp_grt),
    .rsp_less  (rsp_less),
    .rsp_eq    (rsp_eq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {rsp_grt, rsp_less, rsp_eq};
  endfunction

  task automatic set_pair(input int i, input logic [3:0] a,
                          input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  // Inputs already applied in IDLE; run one accept/compare/respond cycle.
  task automatic txn(input string tag, input logic [3:0] exp_ready,
                     input logic [1:0] exp_id, input logic [2:0] exp_f);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    tick();
    chk({tag, "_cmp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmp_ready"}, 32'(req_ready), 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, "_rsp_flags"}, 32'(flags()), 32'(exp_f));
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset held two cycles, then idle.
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(rsp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_flags", 32'(flags()), 32'd0);
      chk("idle_id", 32'(rsp_id), 32'd0);
    end

    // Single requester, three compare outcomes.
    req_valid = 4'b0001;
    set_pair(0, 4'd0, 4'd0);
    txn("r0_eq", 4'b0001, 2'd0, F_EQ);
    set_pair(0, 4'd0, 4'd1);
    txn("r0_less", 4'b0001, 2'd0, F_LESS);
    set_pair(0, 4'd14, 4'd12);
    txn("r0_grt", 4'b0001, 2'd0, F_GRT);
    req_valid = '0;

    // Restart from rr_ptr=0 and hold all requesters.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_pair(i, 4'(i), 4'd2);
    req_valid = 4'b1111;
    txn("rr0", 4'b0001, 2'd0, F_LESS);
    txn("rr1", 4'b0010, 2'd1, F_LESS);
    txn("rr2", 4'b0100, 2'd2, F_EQ);
    txn("rr3", 4'b1000, 2'd3, F_GRT);
    txn("rr_wrap", 4'b0001, 2'd0, F_LESS);
    req_valid = '0;

    // 3 vs 15: unsigned less, signed 3 > -1.
    set_pair(0, 4'd3, 4'd15);
    req_valid = 4'b0001;
`ifdef CMP_SIGNED_EN
    txn("sign", 4'b0001, 2'd0, F_GRT);
`else
    txn("sign", 4'b0001, 2'd0, F_LESS);
`endif

    // Consumer stall: rr_ptr=1 so requester 1 wins.
    set_pair(1, 4'd5, 4'd5);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("stall_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id", 32'(rsp_id), 32'd1);
      chk("stall_flags", 32'(flags()), 32'(F_EQ));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    chk("stall_hold_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("release_valid", 32'(rsp_valid), 32'd0);
    chk("release_flags", 32'(flags()), 32'(F_NONE));
    chk("release_ready", 32'(req_ready), 32'b0100);
    req_valid = '0;
    #1;

    // Reset during CMP drops requester 2's pair.
    set_pair(2, 4'd1, 4'd0);
    req_valid = 4'b0100;
    #1;
    chk("drop_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    set_pair(0, 4'd9, 4'd7);
    req_valid = 4'b0101;
    txn("post_rst", 4'b0001, 2'd0, F_GRT);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
